// File: rtl/ut_uart_pkg.sv
// ut_uart_pkg: FSM state enums, oversampling constants and parity helper
// shared by the UART core and its sub-modules.
package ut_uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    // Data is zero-extended to 9 bits; extra zeros leave the XOR unchanged.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/ut_baud_tick.sv
// ut_baud_tick: oversample tick generator, one-cycle tick every BAUD_DIV clocks.
// A synchronous clr restarts the period so the first tick lands BAUD_DIV cycles later.
module ut_baud_tick #(
    parameter int BAUD_DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] TC_LOAD = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= TC_LOAD;
        end else if (clr || cnt == '0) begin
            cnt <= TC_LOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0) && !clr;

endmodule

// File: rtl/ut_uart_core.sv
// ut_uart_core: full-duplex UART, LSB-first framing with a 16x oversampled receiver.
// Parity generation/checking is compiled in only when UART_PARITY_EN is defined.
module ut_uart_core
    import ut_uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int BAUD_DIV    = 27,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_din,
    input  logic              tx_trigger,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              txd,
    input  logic              rxd,
    output logic [DATA_W-1:0] rx_dout,
    output logic              rx_comp,
    output logic              rx_perr,
    output logic              rx_ferr
);

    localparam logic [3:0] OS_LAST   = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_LOAD  = 4'(MID_SAMPLE - 1);
    localparam logic [3:0] DATA_LAST = 4'(DATA_W - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
`ifdef UART_PARITY_EN
    localparam bit PAR_ON = (PARITY_MODE != PAR_NONE);
`endif

    if (DATA_W < 5 || DATA_W > 9 || BAUD_DIV < 2 || PARITY_MODE < PAR_NONE ||
        PARITY_MODE > PAR_ODD || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_cfg
        $error("ut_uart_core: parameter out of range");
    end

    // ---------------- transmitter ----------------
    tx_state_e         tx_state, tx_state_n;
    logic [DATA_W-1:0] tx_shift, tx_shift_n;
    logic [3:0]        tx_bits, tx_bits_n;
    logic [3:0]        tx_os, tx_os_n;
    logic              txd_n, tx_done_n;
    logic              tx_clr, tx_tick, tx_bit_end, tx_accept;
`ifdef UART_PARITY_EN
    logic              tx_par, tx_par_n;
`endif

    assign tx_busy   = (tx_state != TX_IDLE);
    assign tx_accept = tx_trigger && !tx_busy;

    ut_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tx_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tx_clr),
        .tick (tx_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_shift <= '0;
            tx_bits  <= '0;
            tx_os    <= '0;
            txd      <= 1'b1;
            tx_done  <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_n;
            tx_shift <= tx_shift_n;
            tx_bits  <= tx_bits_n;
            tx_os    <= tx_os_n;
            txd      <= txd_n;
            tx_done  <= tx_done_n;
`ifdef UART_PARITY_EN
            tx_par   <= tx_par_n;
`endif
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_shift_n = tx_shift;
        tx_bits_n  = tx_bits;
        tx_os_n    = tx_os;
        txd_n      = txd;
        tx_done_n  = 1'b0;
        tx_clr     = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_n   = tx_par;
`endif
        tx_bit_end = tx_tick && (tx_os == '0);
        if (tx_tick && tx_os != '0) tx_os_n = tx_os - 1'b1;
        if (tx_bit_end) tx_os_n = OS_LAST;

        case (tx_state)
            TX_IDLE: begin
                if (tx_accept) begin
                    tx_state_n = TX_START;
                    tx_shift_n = tx_din;
                    txd_n      = 1'b0;
                    tx_clr     = 1'b1;
                    tx_os_n    = OS_LAST;
`ifdef UART_PARITY_EN
                    tx_par_n   = parity_bit(9'(tx_din), PARITY_MODE);
`endif
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_n = TX_DATA;
                    txd_n      = tx_shift[0];
                    tx_bits_n  = DATA_LAST;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    if (tx_bits == '0) begin
`ifdef UART_PARITY_EN
                        if (PAR_ON) begin
                            tx_state_n = TX_PARITY;
                            txd_n      = tx_par;
                        end else begin
                            tx_state_n = TX_STOP;
                            txd_n      = 1'b1;
                            tx_bits_n  = STOP_LAST;
                        end
`else
                        tx_state_n = TX_STOP;
                        txd_n      = 1'b1;
                        tx_bits_n  = STOP_LAST;
`endif
                    end else begin
                        // Next data bit comes from bit 1 before the shift lands.
                        tx_shift_n = tx_shift >> 1;
                        txd_n      = tx_shift[1];
                        tx_bits_n  = tx_bits - 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_n = TX_STOP;
                    txd_n      = 1'b1;
                    tx_bits_n  = STOP_LAST;
                end
            end
`endif
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_bits == '0) begin
                        tx_state_n = TX_IDLE;
                        tx_done_n  = 1'b1;
                    end else begin
                        tx_bits_n = tx_bits - 1'b1;
                    end
                end
            end
            default: begin
                tx_state_n = TX_IDLE;
                txd_n      = 1'b1;
            end
        endcase
    end

    // ---------------- receiver ----------------
    logic              rxd_s1, rxd_s2;
    rx_state_e         rx_state, rx_state_n;
    logic [DATA_W-1:0] rx_shift, rx_shift_n, rx_dout_n;
    logic [3:0]        rx_bits, rx_bits_n;
    logic [3:0]        rx_os, rx_os_n;
    logic              rx_ferr_acc, rx_ferr_acc_n;
    logic              rx_comp_n, rx_ferr_n;
    logic              rx_clr, rx_tick, rx_sample;
`ifdef UART_PARITY_EN
    logic              rx_perr_acc, rx_perr_acc_n, rx_perr_n;
`endif

    ut_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_rx_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (rx_clr),
        .tick (rx_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_s1      <= 1'b1;
            rxd_s2      <= 1'b1;
            rx_state    <= RX_IDLE;
            rx_shift    <= '0;
            rx_bits     <= '0;
            rx_os       <= '0;
            rx_ferr_acc <= 1'b0;
            rx_dout     <= '0;
            rx_comp     <= 1'b0;
            rx_ferr     <= 1'b0;
`ifdef UART_PARITY_EN
            rx_perr_acc <= 1'b0;
            rx_perr     <= 1'b0;
`endif
        end else begin
            rxd_s1      <= rxd;
            rxd_s2      <= rxd_s1;
            rx_state    <= rx_state_n;
            rx_shift    <= rx_shift_n;
            rx_bits     <= rx_bits_n;
            rx_os       <= rx_os_n;
            rx_ferr_acc <= rx_ferr_acc_n;
            rx_dout     <= rx_dout_n;
            rx_comp     <= rx_comp_n;
            rx_ferr     <= rx_ferr_n;
`ifdef UART_PARITY_EN
            rx_perr_acc <= rx_perr_acc_n;
            rx_perr     <= rx_perr_n;
`endif
        end
    end

`ifndef UART_PARITY_EN
    assign rx_perr = 1'b0;
`endif

    always_comb begin
        rx_state_n    = rx_state;
        rx_shift_n    = rx_shift;
        rx_bits_n     = rx_bits;
        rx_os_n       = rx_os;
        rx_ferr_acc_n = rx_ferr_acc;
        rx_dout_n     = rx_dout;
        rx_comp_n     = 1'b0;
        rx_ferr_n     = rx_ferr;
        rx_clr        = 1'b0;
`ifdef UART_PARITY_EN
        rx_perr_acc_n = rx_perr_acc;
        rx_perr_n     = rx_perr;
`endif
        rx_sample = rx_tick && (rx_os == '0);
        if (rx_tick && rx_os != '0) rx_os_n = rx_os - 1'b1;
        if (rx_sample) rx_os_n = OS_LAST;

        case (rx_state)
            RX_IDLE: begin
                if (!rxd_s2) begin
                    rx_state_n = RX_START;
                    rx_clr     = 1'b1;
                    rx_os_n    = MID_LOAD;
                end
            end
            RX_START: begin
                if (rx_sample) begin
                    if (rxd_s2) begin
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_state_n = RX_DATA;
                        rx_bits_n  = DATA_LAST;
`ifdef UART_PARITY_EN
                        rx_perr_acc_n = 1'b0;
`endif
                    end
                end
            end
            RX_DATA: begin
                if (rx_sample) begin
                    rx_shift_n = {rxd_s2, rx_shift[DATA_W-1:1]};
                    if (rx_bits == '0) begin
`ifdef UART_PARITY_EN
                        if (PAR_ON) begin
                            rx_state_n = RX_PARITY;
                        end else begin
                            rx_state_n    = RX_STOP;
                            rx_bits_n     = STOP_LAST;
                            rx_ferr_acc_n = 1'b0;
                        end
`else
                        rx_state_n    = RX_STOP;
                        rx_bits_n     = STOP_LAST;
                        rx_ferr_acc_n = 1'b0;
`endif
                    end else begin
                        rx_bits_n = rx_bits - 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (rx_sample) begin
                    rx_perr_acc_n = rxd_s2 ^ parity_bit(9'(rx_shift), PARITY_MODE);
                    rx_state_n    = RX_STOP;
                    rx_bits_n     = STOP_LAST;
                    rx_ferr_acc_n = 1'b0;
                end
            end
`endif
            RX_STOP: begin
                if (rx_sample) begin
                    rx_ferr_acc_n = rx_ferr_acc | ~rxd_s2;
                    if (rx_bits == '0) begin
                        rx_comp_n  = 1'b1;
                        rx_dout_n  = rx_shift;
                        rx_ferr_n  = rx_ferr_acc_n;
`ifdef UART_PARITY_EN
                        rx_perr_n  = rx_perr_acc;
`endif
                        // A low stop bit may be a break; hold off until the line idles.
                        rx_state_n = rx_ferr_acc_n ? RX_WAIT_HIGH : RX_IDLE;
                    end else begin
                        rx_bits_n = rx_bits - 1'b1;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (rxd_s2) rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ut_uart_core.sv
// tb_ut_uart_core: randomized scoreboard bench; frame-level model of the serial line,
// TX/RX monitors compare against queued expectations.
module tb_ut_uart_core;

    localparam int DW = 8;
    localparam int BD = 4;
    localparam int SB = 1;
`ifdef UART_PARITY_EN
    localparam int PM = 2;
    localparam int PB = 1;
`else
    localparam int PM = 0;
    localparam int PB = 0;
`endif
    localparam int BITC    = 16 * BD;
    localparam int NBITS   = 1 + DW + PB + SB;
    localparam int LAT_NOM = (NBITS - 1) * BITC + BITC / 2 + 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          perr;
        logic          ferr;
    } rx_exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] tx_din = '0;
    logic          tx_trigger = 1'b0;
    logic          tx_busy, tx_done, txd, rxd;
    logic [DW-1:0] rx_dout;
    logic          rx_comp, rx_perr, rx_ferr;
    logic          loop_en = 1'b1;
    logic          rxd_drv = 1'b1;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [DW-1:0] tx_q[$];
    rx_exp_t       rx_q[$];

    assign rxd = loop_en ? txd : rxd_drv;

    ut_uart_core #(
        .DATA_W      (DW),
        .BAUD_DIV    (BD),
        .STOP_BITS   (SB),
        .PARITY_MODE (PM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_din     (tx_din),
        .tx_trigger (tx_trigger),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .txd        (txd),
        .rxd        (rxd),
        .rx_dout    (rx_dout),
        .rx_comp    (rx_comp),
        .rx_perr    (rx_perr),
        .rx_ferr    (rx_ferr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Serial line level of bit i of a frame carrying d.
    function automatic logic frame_bit(input logic [DW-1:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= DW) return d[i-1];
        if (PB != 0 && i == DW + 1) return (^d) ^ (PM == 2);
        return 1'b1;
    endfunction

    // TX monitor: every cycle of a frame is compared with the expected line level.
    logic [DW-1:0] mon_d;
    int            mon_pos;
    bit            mon_act = 1'b0;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            mon_act = 1'b0;
        end else begin
            if (!mon_act && tx_busy) begin
                if (tx_q.size() == 0) begin
                    chk("tx_unexpected_frame", 1, 0);
                end else begin
                    mon_d   = tx_q.pop_front();
                    mon_act = 1'b1;
                    mon_pos = 0;
                end
            end
            if (mon_act) begin
                if (mon_pos < NBITS * BITC) begin
                    chk("txd_bit", int'(txd), int'(frame_bit(mon_d, mon_pos / BITC)));
                    if (mon_pos % BITC == 0) chk("tx_busy_in_frame", int'(tx_busy), 1);
                    if (tx_done) chk("tx_done_early", 1, 0);
                end else begin
                    chk("tx_busy_end", int'(tx_busy), 0);
                    chk("tx_done_end", int'(tx_done), 1);
                    mon_act = 1'b0;
                end
                mon_pos++;
            end else if (tx_done) begin
                chk("tx_done_spurious", 1, 0);
            end
        end
    end

    // RX monitor: each rx_comp pops one expected word.
    rx_exp_t mon_e;
    initial forever begin
        @(negedge clk);
        if (!rst && rx_comp) begin
            if (rx_q.size() == 0) begin
                chk("rx_unexpected_comp", 1, 0);
            end else begin
                mon_e = rx_q.pop_front();
                chk("rx_dout", int'(rx_dout), int'(mon_e.data));
                chk("rx_perr", int'(rx_perr), int'(mon_e.perr));
                chk("rx_ferr", int'(rx_ferr), int'(mon_e.ferr));
            end
        end
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: bench exceeded cycle limit");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (tx_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (tx_busy) chk("tx_idle_timeout", 1, 0);
    endtask

    task automatic send(input logic [DW-1:0] d);
        wait_idle(NBITS * BITC + 50);
        tx_din     = d;
        tx_trigger = 1'b1;
        tx_q.push_back(d);
        if (loop_en) rx_q.push_back('{data: d, perr: 1'b0, ferr: 1'b0});
        @(negedge clk);
        tx_trigger = 1'b0;
        tx_din     = DW'($urandom);
    endtask

    task automatic drive_frame(input logic [DW-1:0] d, input bit flip_par, input bit bad_stop);
        logic b;
        loop_en = 1'b0;
        rx_q.push_back('{data: d, perr: (flip_par && PB != 0), ferr: bad_stop});
        for (int i = 0; i < NBITS; i++) begin
            b = frame_bit(d, i);
            if (PB != 0 && i == DW + 1 && flip_par) b = ~b;
            if (i >= NBITS - SB && bad_stop) b = 1'b0;
            rxd_drv = b;
            repeat (BITC) @(negedge clk);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((rx_q.size() != 0 || tx_q.size() != 0 || tx_busy || mon_act) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("drain_timeout", 1, 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int t0, t1, n;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_txd", int'(txd), 1);
        chk("rst_tx_busy", int'(tx_busy), 0);
        chk("rst_tx_done", int'(tx_done), 0);
        chk("rst_rx_dout", int'(rx_dout), 0);
        chk("rst_rx_comp", int'(rx_comp), 0);
        chk("rst_rx_perr", int'(rx_perr), 0);
        chk("rst_rx_ferr", int'(rx_ferr), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // A5 frame, exact waveform via TX monitor, looped back to RX
        send(8'hA5);
        drain(3 * NBITS * BITC);

        // 3C loopback latency from start edge to rx_comp
        send(8'h3C);
        t0 = cyc;
        chk("start_bit_low", int'(txd), 0);
        n = 0;
        while (!rx_comp && n < 2 * NBITS * BITC) begin
            @(negedge clk);
            n++;
        end
        t1 = cyc;
        chk("rx_comp_seen", int'(rx_comp), 1);
        chk("rx_latency_window", int'((t1 - t0) >= LAT_NOM - 2 && (t1 - t0) <= LAT_NOM + 2), 1);
        drain(3 * NBITS * BITC);

        // short low glitch is rejected, then a real frame
        loop_en = 1'b0;
        rxd_drv = 1'b0;
        repeat (20) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (BITC) @(negedge clk);
        drive_frame(8'h55, 1'b0, 1'b0);
        drain(2 * NBITS * BITC);
        chk("ferr_clear_after_good", int'(rx_ferr), 0);

        // framing error followed by a long break
        drive_frame(8'hFF, 1'b0, 1'b1);
        repeat (2000) @(negedge clk);
        chk("ferr_frame_consumed", rx_q.size(), 0);
        chk("ferr_held", int'(rx_ferr), 1);
        rxd_drv = 1'b1;
        repeat (BITC) @(negedge clk);

        // parity: 01 through the line, then a frame with the parity bit flipped
        drive_frame(8'h01, 1'b0, 1'b0);
        drive_frame(8'h01, 1'b1, 1'b0);
        drive_frame(8'h80, 1'b0, 1'b0);
        drain(2 * NBITS * BITC);
        chk("ferr_cleared", int'(rx_ferr), 0);

        // random direct-driven frames
        for (int i = 0; i < 8; i++) begin
            logic [DW-1:0] d;
            bit bad;
            d   = DW'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            drive_frame(d, bit'($urandom_range(0, 1)), bad);
            if (bad) begin
                rxd_drv = 1'b1;
                repeat (BITC) @(negedge clk);
            end
        end
        rxd_drv = 1'b1;
        drain(2 * NBITS * BITC);

        // random loopback frames, some back-to-back
        loop_en = 1'b1;
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                wait_idle(NBITS * BITC + 50);
                repeat ($urandom_range(0, 40)) @(negedge clk);
            end
            send(DW'($urandom));
        end
        drain(4 * NBITS * BITC);

        // trigger while busy is ignored
        send(8'h5A);
        repeat (99) @(negedge clk);
        tx_din     = 8'hC3;
        tx_trigger = 1'b1;
        @(negedge clk);
        tx_trigger = 1'b0;
        drain(3 * NBITS * BITC);

        // asynchronous reset mid-frame
        send(8'h96);
        repeat (300) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_txd", int'(txd), 1);
        chk("midrst_tx_busy", int'(tx_busy), 0);
        chk("midrst_rx_comp", int'(rx_comp), 0);
        tx_q.delete();
        rx_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_tx_done", int'(tx_done), 0);
        send(8'h0F);
        drain(3 * NBITS * BITC);

        chk("tx_queue_empty", tx_q.size(), 0);
        chk("rx_queue_empty", rx_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
